proc_fetch_seq: RTL

// - Instruction fetch sequencer sitting directly upstream of the 16-bit multicycle processor.
// - It owns the program counter and reads instruction/immediate words from a synchronous program memory.
// - It drives the processor's DIN and Run and watches Done to pace one instruction at a time.
// - For mvi (opcode DIN[15:13]=3'b001) it prefetches the immediate word, so DIN carries data in processor T1.

---
 rtl/proc_fetch_seq_pkg.sv | 27 ++
 rtl/proc_fetch_seq_pc_counter.sv | 29 ++
 rtl/proc_fetch_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/proc_fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer: opcode field,
// opcode values and FSM state encoding.
package proc_fetch_seq_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_I,
    S_WAIT_I,
    S_RD_D,
    S_WAIT_D,
    S_ISSUE,
    S_EXEC
  } state_e;

  function automatic logic is_mvi(input logic [15:0] word);
    return word[OPC_MSB:OPC_LSB] == OP_MVI;
  endfunction

endpackage

// File: rtl/proc_fetch_seq_pc_counter.sv
// Program counter for the fetch sequencer: synchronous load of the start
// address, increment with natural AW-bit wrap.
module proc_fetch_seq_pc_counter #(
  parameter int              AW       = 8,
  parameter logic [AW-1:0]   START_PC = '0
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          load_i,
  input  logic          inc_i,
  output logic [AW-1:0] pc_o
);

  logic [AW-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i)     pc_d = START_PC;
    else if (inc_i) pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) pc_q <= START_PC;
    else         pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/proc_fetch_seq.sv
// Fetch sequencer in front of the multicycle processor: reads instruction
// (and mvi immediate) words, pulses Run, then waits for Done or a timeout.
// IDLE wait Start | RD_x/WAIT_x read word x | ISSUE Run + DIN=ibuf | EXEC DIN=dbuf, wait Done
module proc_fetch_seq
  import proc_fetch_seq_pkg::*;
#(
  parameter int AW         = 8,
  parameter int MEM_LAT    = 1,
  parameter int START_ADDR = 0,
  parameter int DONE_TMO   = 3
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  input  logic          Stop,
  output logic [AW-1:0] MemAddr,
  output logic          MemRd,
  input  logic [15:0]   MemData,
  output logic [15:0]   DIN,
  output logic          Run,
  input  logic          Done,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Illegal
);

  localparam int             LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int             TMO_W    = (DONE_TMO > 1) ? $clog2(DONE_TMO) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TMO - 1);
  localparam logic [AW-1:0]    START_PC = AW'(START_ADDR);

  state_e           state_q, state_d;
  logic [15:0]      ibuf_q, ibuf_d;
  logic [15:0]      dbuf_q, dbuf_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             ill_q, ill_d;
  logic             stop_q, stop_d;
  logic             pc_load, pc_inc;
  logic             stop_seen;

  proc_fetch_seq_pc_counter #(
    .AW       (AW),
    .START_PC (START_PC)
  ) u_pc (
    .Clock  (Clock),
    .Resetn (Resetn),
    .load_i (pc_load),
    .inc_i  (pc_inc),
    .pc_o   (PC)
  );

  assign stop_seen = stop_q | Stop;

  always_comb begin
    state_d = state_q;
    ibuf_d  = ibuf_q;
    dbuf_d  = dbuf_q;
    lat_d   = lat_q;
    tmo_d   = tmo_q;
    ill_d   = ill_q;
    stop_d  = (state_q != S_IDLE) ? stop_seen : 1'b0;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    MemAddr = '0;
    MemRd   = 1'b0;
    DIN     = '0;
    Run     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start && !Stop) begin
          state_d = S_RD_I;
          pc_load = 1'b1;
          ill_d   = 1'b0;
        end
      end
      S_RD_I, S_RD_D: begin
        MemRd   = 1'b1;
        MemAddr = PC;
        pc_inc  = 1'b1;
        lat_d   = LAT_INIT;
        state_d = (state_q == S_RD_I) ? S_WAIT_I : S_WAIT_D;
      end
      S_WAIT_I: begin
        if (lat_q == '0) begin
          ibuf_d  = MemData;
          state_d = is_mvi(MemData) ? S_RD_D : S_ISSUE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_WAIT_D: begin
        if (lat_q == '0) begin
          dbuf_d  = MemData;
          state_d = S_ISSUE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_ISSUE: begin
        DIN     = ibuf_q;
        Run     = 1'b1;
        tmo_d   = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        DIN = dbuf_q;
        // A timeout exits like Done; the processor falls back to T0 on its own.
        if (Done || (tmo_q == TMO_LAST)) begin
          if (!Done) ill_d = 1'b1;
          if (stop_seen) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
          end else begin
            state_d = S_RD_I;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      ibuf_q  <= '0;
      dbuf_q  <= '0;
      lat_q   <= '0;
      tmo_q   <= '0;
      ill_q   <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ibuf_q  <= ibuf_d;
      dbuf_q  <= dbuf_d;
      lat_q   <= lat_d;
      tmo_q   <= tmo_d;
      ill_q   <= ill_d;
      stop_q  <= stop_d;
    end
  end

  assign Busy    = (state_q != S_IDLE);
  assign Illegal = ill_q;

endmodule
